// File: rtl/sat_pkg.sv
// Shared definitions for the variable-table cluster.
// Contents:
//   VT_ADDR_W_DEFAULT - default variable address width, shared with the cluster
//   VT_WORD_W_DEFAULT - host word width used by the loader
//   vt_state_e        - loader FSM state encoding (IDLE, LOAD, CLEAR, DONE)
package sat_pkg;

  localparam int VT_ADDR_W_DEFAULT = 11;
  localparam int VT_WORD_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } vt_state_e;

endpackage

// File: rtl/vt_loader_shifter.sv
// Word shift register and bit counter for the variable-table loader.
// A load captures a host word and the number of its bits still to be
// written. Each shift drops the LSB and decrements the counter.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   load_i         capture word_i / count_i (wins over shift_i)
//   shift_i        consume the current LSB
//   word_i         host word
//   count_i        number of valid bits in word_i
//   lsb_o          bit to be written this cycle
//   empty_o        no bits remaining
//   last_o         exactly one bit remaining
module vt_loader_shifter
  import sat_pkg::*;
#(
  parameter int WORD_WIDTH = VT_WORD_W_DEFAULT,
  parameter int CNT_WIDTH  = $clog2(WORD_WIDTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [WORD_WIDTH-1:0] word_i,
  input  logic [CNT_WIDTH-1:0]  count_i,
  output logic                  lsb_o,
  output logic                  empty_o,
  output logic                  last_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [WORD_WIDTH-1:0] sr_q, sr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  // Next-state of shift register and counter; a load replaces the word whose
  // last bit is being consumed in the same cycle.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = word_i;
      cnt_d = count_i;
    end else if (shift_i && (cnt_q != '0)) begin
      sr_d  = sr_q >> 1;
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
    end
  end

  // Shift register and bit counter state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign lsb_o   = sr_q[0];
  assign empty_o = (cnt_q == '0);
  assign last_o  = (cnt_q == CNT_ONE);

endmodule

// File: rtl/variable_table_loader.sv
// Host-side initiator that fills variables 0..num_vars-1 of every table in
// the cluster, one bit per cycle, from packed host words (LSB first).
// Optional build macro: VT_LOADER_CLEAR_EN - after the last loaded variable,
// zero-fill addresses num_vars..2^VARIABLE_ADDRESS_WIDTH-1 before DONE.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   start_i           begin a load (sampled in IDLE only)
//   num_vars_i        variables to write, clamped to 2^VARIABLE_ADDRESS_WIDTH
//   s_valid_i/s_ready_o/s_data_i  host word stream
//   busy_o            high while loading (or clearing)
//   done_o            one-cycle pulse after the final write
//   axi_en_o/axi_wr_en_o/axi_addr_o/axi_data_o  broadcast write port
module variable_table_loader
  import sat_pkg::*;
#(
  parameter int VARIABLE_ADDRESS_WIDTH = VT_ADDR_W_DEFAULT,
  parameter int WORD_WIDTH             = VT_WORD_W_DEFAULT
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic [VARIABLE_ADDRESS_WIDTH:0]   num_vars_i,
  input  logic                              s_valid_i,
  output logic                              s_ready_o,
  input  logic [WORD_WIDTH-1:0]             s_data_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              axi_en_o,
  output logic                              axi_wr_en_o,
  output logic [VARIABLE_ADDRESS_WIDTH-1:0] axi_addr_o,
  output logic                              axi_data_o
);

  localparam int CW = VARIABLE_ADDRESS_WIDTH + 1;
  localparam int BW = $clog2(WORD_WIDTH + 1);
  // Address counter is one bit wider so a full table ends at FULL, not 0.
  localparam logic [CW-1:0] FULL     = {1'b1, {VARIABLE_ADDRESS_WIDTH{1'b0}}};
  localparam logic [CW-1:0] WORD_CNT = CW'(WORD_WIDTH);
  localparam logic [CW-1:0] ONE      = CW'(1);

  vt_state_e state_q, state_d;
  logic [CW-1:0] addr_q, addr_d, nvars_q, nvars_d;
  logic [CW-1:0] rem_s, nvars_clamped_s;
  logic [BW-1:0] count_s;
  logic          lsb_s, empty_s, last_s, accept_s;
  logic          wr_s, wr_data_s, shift_s;

  logic                              axi_en_q, axi_data_q, busy_q, done_q;
  logic [VARIABLE_ADDRESS_WIDTH-1:0] axi_addr_q;

  // Variables not yet captured into the shifter. Only meaningful when the
  // shifter holds at most one bit, which is exactly when a word may be taken.
  assign rem_s           = nvars_q - addr_q - {{(CW-1){1'b0}}, last_s};
  assign count_s         = (rem_s >= WORD_CNT) ? BW'(WORD_WIDTH) : BW'(rem_s);
  assign nvars_clamped_s = (num_vars_i > FULL) ? FULL : num_vars_i;
  assign s_ready_o       = (state_q == ST_LOAD) && (rem_s != '0) && (empty_s || last_s);
  assign accept_s        = s_ready_o && s_valid_i;

  vt_loader_shifter #(
    .WORD_WIDTH (WORD_WIDTH),
    .CNT_WIDTH  (BW)
  ) u_shifter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (accept_s),
    .shift_i (shift_s),
    .word_i  (s_data_i),
    .count_i (count_s),
    .lsb_o   (lsb_s),
    .empty_o (empty_s),
    .last_o  (last_s)
  );

  // FSM next state, address counter and write issue decision.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    nvars_d   = nvars_q;
    wr_s      = 1'b0;
    wr_data_s = 1'b0;
    shift_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d  = '0;
          nvars_d = nvars_clamped_s;
          state_d = (num_vars_i == '0) ? ST_DONE : ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (!empty_s) begin
          wr_s      = 1'b1;
          wr_data_s = lsb_s;
          shift_s   = 1'b1;
          addr_d    = addr_q + ONE;
        end else if (rem_s == '0) begin
          // All variables written; the last write is on the port this cycle.
`ifdef VT_LOADER_CLEAR_EN
          state_d = (addr_q == FULL) ? ST_DONE : ST_CLEAR;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_LOAD;
        end
      end
`ifdef VT_LOADER_CLEAR_EN
      ST_CLEAR: begin
        if (addr_q == FULL) begin
          state_d = ST_DONE;
        end else begin
          wr_s   = 1'b1;
          addr_d = addr_q + ONE;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      nvars_q    <= '0;
      axi_en_q   <= 1'b0;
      axi_data_q <= 1'b0;
      axi_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      nvars_q    <= nvars_d;
      axi_en_q   <= wr_s;
      axi_data_q <= wr_data_s;
      // Address holds across stalls.
      if (wr_s) begin
        axi_addr_q <= addr_q[VARIABLE_ADDRESS_WIDTH-1:0];
      end else begin
        axi_addr_q <= axi_addr_q;
      end
      busy_q <= (state_d == ST_LOAD) || (state_d == ST_CLEAR);
      done_q <= (state_d == ST_DONE);
    end
  end

  assign axi_en_o    = axi_en_q;
  assign axi_wr_en_o = axi_en_q;
  assign axi_addr_o  = axi_addr_q;
  assign axi_data_o  = axi_data_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_variable_table_loader.sv
module tb_variable_table_loader;

  localparam int AW = 11;
  localparam int WW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i, start_i, s_valid_i, s_ready_o;
  logic [AW:0]   num_vars_i;
  logic [WW-1:0] s_data_i;
  logic          busy_o, done_o, axi_en_o, axi_wr_en_o, axi_data_o;
  logic [AW-1:0] axi_addr_o;

  always #5 clk_i = ~clk_i;

  variable_table_loader #(.VARIABLE_ADDRESS_WIDTH(AW), .WORD_WIDTH(WW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .num_vars_i  (num_vars_i),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .s_data_i    (s_data_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .axi_en_o    (axi_en_o),
    .axi_wr_en_o (axi_wr_en_o),
    .axi_addr_o  (axi_addr_o),
    .axi_data_o  (axi_data_o)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          exp_done   = 0;
  int          n_checks   = 0;
  int          n_fail     = 0;
  int          wr_seen    = 0;
  int          done_seen  = 0;
  int          acc_seen   = 0;
  int          idle_busy  = 0;
  logic [31:0] words [64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every write, tracks done/accept/idle.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (s_valid_i && s_ready_o) acc_seen++;
      if (busy_o && !axi_en_o) idle_busy++;
      if (axi_en_o) begin
        wr_seen++;
        check("wr_en_eq_en", axi_wr_en_o, 1);
        check("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("addr", axi_addr_o, mon_e.addr);
          check("data", axi_data_o, mon_e.data);
        end
      end
      if (done_o) begin
        done_seen++;
        check("done_expected", exp_done > 0, 1);
        check("writes_before_done", exp_q.size(), 0);
        if (exp_done > 0) exp_done--;
      end
    end
  end

  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge clk_i);
    while (!s_ready_o && t < 200) begin
      t++;
      @(negedge clk_i);
    end
    check("ready_seen", s_ready_o, 1);
  endtask

  task automatic push_expected(input int nv_c);
    wr_t e;
    for (int a = 0; a < nv_c; a++) begin
      e.addr = a[AW-1:0];
      e.data = words[a / 32][a % 32];
      exp_q.push_back(e);
    end
`ifdef VT_LOADER_CLEAR_EN
    for (int a = nv_c; a < (1 << AW); a++) begin
      if (nv_c != 0) begin
        e.addr = a[AW-1:0];
        e.data = 1'b0;
        exp_q.push_back(e);
      end
    end
`endif
  endtask

  task automatic start_load(input int nv);
    start_i    = 1'b1;
    num_vars_i = nv[AW:0];
    @(posedge clk_i); #1;
    start_i    = 1'b0;
  endtask

  // Full load: nv variables from words[], gap idle cycles between words.
  task automatic run_load(input int nv, input int gap);
    int nv_c, nw, base_acc, base_idle, base_done, exp_idle, t;
    nv_c = (nv > (1 << AW)) ? (1 << AW) : nv;
    nw   = (nv_c + 31) / 32;
    check("queue_empty_before", exp_q.size(), 0);
    push_expected(nv_c);
    exp_done++;
    base_acc  = acc_seen;
    base_idle = idle_busy;
    base_done = done_seen;
    exp_idle  = (nv_c == 0) ? 0 : 2 + gap * (nw - 1);
`ifdef VT_LOADER_CLEAR_EN
    if (nv_c != 0 && nv_c < (1 << AW)) exp_idle++;
`endif
    start_load(nv);
    check("busy_after_start", busy_o, nv_c != 0);
    check("done_after_start", done_o, nv_c == 0);
    for (int i = 0; i < nw; i++) begin
      s_valid_i = 1'b1;
      s_data_i  = words[i];
      wait_ready();
      @(posedge clk_i); #1;
      if (gap > 0 && i < nw - 1) begin
        s_valid_i = 1'b0;
        wait_ready();
        repeat (gap) @(posedge clk_i);
        #1;
      end
    end
    // Offer junk after the final word: it must never be accepted.
    s_valid_i = 1'b1;
    s_data_i  = 32'hDEAD_BEEF;
    t = 0;
    while (done_seen == base_done && t < 5000) begin
      t++;
      @(posedge clk_i); #1;
    end
    s_valid_i = 1'b0;
    check("done_count", done_seen - base_done, 1);
    check("words_accepted", acc_seen - base_acc, nw);
    check("busy_idle_cycles", idle_busy - base_idle, exp_idle);
    @(posedge clk_i); #1;
    check("busy_low_after", busy_o, 0);
  endtask

  initial begin
    int base, t;
    rst_i = 1'b1; start_i = 1'b0; num_vars_i = '0; s_valid_i = 1'b0; s_data_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_axi_en", axi_en_o, 0);
    check("rst_wr_en", axi_wr_en_o, 0);
    check("rst_addr", axi_addr_o, 0);
    check("rst_data", axi_data_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_ready", s_ready_o, 0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // 5 variables from 0x16: data 0,1,1,0,1.
    words[0] = 32'h0000_0016;
    run_load(5, 0);

    // 70 variables, contiguous, then with 3-cycle host stalls.
    words[0] = 32'hFFFF_FFFF; words[1] = 32'h0000_0000; words[2] = 32'h0000_0005;
    run_load(70, 0);
    run_load(70, 3);

    // Zero variables: done next cycle, no writes.
    run_load(0, 0);

    // Over-range count clamps to the full table, last write at 0x7FF.
    for (int i = 0; i < 64; i++) words[i] = 32'h9E37_79B9 ^ (i * 32'h0101_0101);
    run_load(4095, 0);

    // Reset at write 10 of a 40-variable load.
    words[0] = 32'hA5A5_0F0F; words[1] = 32'h1234_5678;
    push_expected(40);
    base = wr_seen;
    start_load(40);
    s_valid_i = 1'b1;
    s_data_i  = words[0];
    t = 0;
    while (wr_seen - base < 10 && t < 200) begin
      t++;
      @(negedge clk_i);
    end
    check("abort_reached_write10", wr_seen - base >= 10, 1);
    s_data_i = words[1];
    @(posedge clk_i); #1;
    rst_i     = 1'b1;
    s_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_q.delete();
    check("abort_axi_en", axi_en_o, 0);
    check("abort_addr", axi_addr_o, 0);
    check("abort_data", axi_data_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    check("abort_ready", s_ready_o, 0);
    base = done_seen;
    repeat (5) @(posedge clk_i);
    #1;
    check("abort_no_done", done_seen, base);
    run_load(40, 0);

    // Near-full table: zero-fill of the tail when clearing is built in.
    for (int i = 0; i < 64; i++) words[i] = 32'hC3C3_5A5A ^ i;
    run_load(2040, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
